bsg_downstream_data_out_wide: RTL and testbench

- Parametrised core-side drain for the BSG offchip downstream channel.
- Reads narrow entries from the channel's circular receive buffer through a combinational read port, and packs RATIO consecutive entries into one CORE_W word.
- Presents that word to the core with a registered valid/ready handshake.
- Returns credits to the IO side as batched token pulses. Replaces the fixed 16-to-32, two-phase drain; adds a real output handshake, which the fixed version lacks.

---
 rtl/bsg_offchip_pkg.sv | 22 ++
 rtl/bsg_offchip_token_gen.sv | 31 +++
 rtl/bsg_downstream_data_out_wide.sv | 100 ++++++++++
 tb/tb_bsg_downstream_data_out_wide.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_offchip_pkg.sv
// Shared defaults and helpers for the BSG offchip channel.
// Used by the downstream drain and the credit paths.
package bsg_offchip_pkg;

  localparam int ENTRY_W_DEF     = 16;
  localparam int RATIO_DEF       = 2;
  localparam int DEPTH_DEF       = 64;
  localparam int TOKEN_BATCH_DEF = 4;

  // Pointer index width for a power-of-two buffer depth.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // LSB of slice k in a packed word; slice 0 sits at the MSB end.
  function automatic int slice_lsb(input int k,
                                   input int entry_w,
                                   input int ratio);
    return (ratio - 1 - k) * entry_w;
  endfunction

endpackage

// File: rtl/bsg_offchip_token_gen.sv
// Batched credit return: one pulse per TOKEN_BATCH consumes.
// Shared by the downstream drain and the upstream credit path.
module bsg_offchip_token_gen #(
  parameter int TOKEN_BATCH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic consume,
  output logic token
);

  localparam int CW = (TOKEN_BATCH > 1) ? $clog2(TOKEN_BATCH) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(TOKEN_BATCH - 1));

  // Count consumes; pulse for one cycle when a batch completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      token <= 1'b0;
    end else begin
      token <= consume && wrap;
      if (consume)
        cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bsg_downstream_data_out_wide.sv
// Core-side drain of the offchip downstream receive buffer.
// Packs RATIO entries per core word, valid/ready out, batched credits.
module bsg_downstream_data_out_wide
  import bsg_offchip_pkg::*;
#(
  parameter  int ENTRY_W     = ENTRY_W_DEF,
  parameter  int RATIO       = RATIO_DEF,
  parameter  int DEPTH       = DEPTH_DEF,
  parameter  int TOKEN_BATCH = TOKEN_BATCH_DEF,
  localparam int PTR_W       = ptr_w(DEPTH),
  localparam int CORE_W      = ENTRY_W * RATIO
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PTR_W:0]    wptr,
  output logic [PTR_W:0]    rptr,
  output logic [PTR_W-1:0]  buf_addr,
  input  logic [ENTRY_W-1:0] buf_data,
  output logic              full,
  output logic [CORE_W-1:0] core_data_out,
  output logic              core_valid_out,
  input  logic              core_ready,
  output logic              io_token_out
);

  localparam int PH_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [PH_W-1:0]   phase;
  logic              empty;
  logic              out_free;
  logic              last;
  logic              rd;
  logic [PTR_W:0]    rptr_next;
  logic [CORE_W-1:0] word;

  assign buf_addr  = rptr[PTR_W-1:0];
  assign empty     = (wptr == rptr);
  assign out_free  = !core_valid_out || core_ready;
  assign last      = (phase == PH_W'(RATIO - 1));
  assign rd        = !empty && (!last || out_free);
  assign rptr_next = rd ? rptr + 1'b1 : rptr;

  // Advance read pointer and slot phase; full is judged post-read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr  <= '0;
      phase <= '0;
      full  <= 1'b0;
    end else begin
      rptr <= rptr_next;
      full <= (wptr[PTR_W] != rptr_next[PTR_W]) &&
              (wptr[PTR_W-1:0] == rptr_next[PTR_W-1:0]);
      if (rd)
        phase <= last ? '0 : phase + 1'b1;
    end
  end

  if (RATIO > 1) begin : g_acc
    logic [(RATIO-1)*ENTRY_W-1:0] acc;

    // Collect leading entries; keeps running while a word is held.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        acc <= '0;
      end else if (rd && !last) begin
        for (int k = 0; k < RATIO - 1; k++)
          if (phase == PH_W'(k))
            acc[slice_lsb(k, ENTRY_W, RATIO) - ENTRY_W +: ENTRY_W]
              <= buf_data;
      end
    end

    assign word = {acc, buf_data};
  end else begin : g_noacc
    assign word = buf_data;
  end

  // Output register: load on final read, drop on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_data_out  <= '0;
      core_valid_out <= 1'b0;
    end else if (rd && last) begin
      core_data_out  <= word;
      core_valid_out <= 1'b1;
    end else if (core_valid_out && core_ready) begin
      core_valid_out <= 1'b0;
    end
  end

  bsg_offchip_token_gen #(
    .TOKEN_BATCH(TOKEN_BATCH)
  ) u_tok (
    .clk    (clk),
    .rst_n  (rst_n),
    .consume(rd),
    .token  (io_token_out)
  );

endmodule

// File: tb/tb_bsg_downstream_data_out_wide.sv
// Directed/random bench for the downstream wide drain.
// Scoreboard packs written entries into expected core words.
module tb_bsg_downstream_data_out_wide;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [6:0]  wptr, rptr;
  logic [5:0]  buf_addr;
  logic [15:0] buf_data;
  logic        full;
  logic [31:0] dout;
  logic        valid, ready, tok;
  logic [15:0] mem [64];

  logic [6:0]  wptr1, rptr1;
  logic [5:0]  addr1;
  logic [31:0] bdata1;
  logic        full1;
  logic [31:0] dout1;
  logic        valid1, ready1, tok1;
  logic [31:0] mem1 [64];

  assign buf_data = mem[buf_addr];
  assign bdata1   = mem1[addr1];

  bsg_downstream_data_out_wide u0 (
    .clk(clk), .rst_n(rst_n), .wptr(wptr), .rptr(rptr),
    .buf_addr(buf_addr), .buf_data(buf_data), .full(full),
    .core_data_out(dout), .core_valid_out(valid),
    .core_ready(ready), .io_token_out(tok)
  );

  bsg_downstream_data_out_wide #(
    .ENTRY_W(32), .RATIO(1), .DEPTH(64), .TOKEN_BATCH(4)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .wptr(wptr1), .rptr(rptr1),
    .buf_addr(addr1), .buf_data(bdata1), .full(full1),
    .core_data_out(dout1), .core_valid_out(valid1),
    .core_ready(ready1), .io_token_out(tok1)
  );

  int errors = 0;
  int checks = 0;
  int toks, words;
  logic prev_tok;
  logic [15:0] exp_q [$];
  logic [15:0] hi, lo;
  logic [15:0] b [6];
  logic [31:0] e [8];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d);
    mem[wptr[5:0]] = d;
    exp_q.push_back(d);
    wptr = wptr + 1'b1;
  endtask

  task automatic push1(input logic [31:0] d);
    mem1[wptr1[5:0]] = d;
    wptr1 = wptr1 + 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    wptr  = '0;
    wptr1 = '0;
    exp_q.delete();
    step(1);
    rst_n = 1'b1;
  endtask

  // Scoreboard: every accepted word must be the next two entries.
  always @(negedge clk) begin
    if (!rst_n) begin
      toks = 0;
      words = 0;
      prev_tok = 1'b0;
    end else begin
      if (tok) begin
        toks++;
        chk("tok_one_cycle", prev_tok, 0);
      end
      prev_tok = tok;
      if (valid && ready) begin
        if (exp_q.size() < 2) begin
          chk("word_underflow", exp_q.size(), 2);
        end else begin
          hi = exp_q.pop_front();
          lo = exp_q.pop_front();
          words++;
          chk("word_order", dout, {hi, lo});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    wptr = '0; wptr1 = '0;
    ready = 1'b0; ready1 = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      mem1[i] = '0;
    end
    step(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rptr", rptr, 0);
    chk("rst_valid", valid, 0);
    chk("rst_tok", tok, 0);
    chk("rst_full", full, 0);
    chk("rst_data", dout, 0);
    chk("rst_rptr1", rptr1, 0);
    chk("rst_valid1", valid1, 0);

    // basic pack
    step(1);
    ready = 1'b1;
    push(16'hAAAA);
    push(16'h5555);
    step(2);
    @(negedge clk);
    chk("pack_valid", valid, 1);
    chk("pack_data", dout, 32'hAAAA5555);
    chk("pack_rptr", rptr, 2);
    @(negedge clk);
    chk("pack_valid_drop", valid, 0);

    // backpressure
    step(1);
    ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b[i] = 16'($urandom());
      push(b[i]);
    end
    step(8);
    @(negedge clk);
    chk("bp_stall_rptr", rptr, 5);
    chk("bp_valid", valid, 1);
    chk("bp_hold1", dout, {b[0], b[1]});
    step(3);
    @(negedge clk);
    chk("bp_hold2", dout, {b[0], b[1]});
    chk("bp_stall_rptr2", rptr, 5);
    step(1);
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_valid_kept", valid, 1);
    chk("bp_word2", dout, {b[2], b[3]});
    chk("bp_rptr6", rptr, 6);
    step(6);
    @(negedge clk);
    chk("bp_rptr_end", rptr, 8);
    chk("bp_words", words, 4);
    chk("bp_toks", toks, 2);

    // token timing over 8 streamed entries
    step(1);
    for (int i = 0; i < 8; i++) push(16'($urandom()));
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("tok_pulse", tok, (i == 4 || i == 8) ? 1 : 0);
    end
    chk("tok_total", toks, 4);
    chk("tok_rptr", rptr, 16);
    chk("tok_words", words, 8);

    // wrap and full
    step(1);
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 4; i++) push(16'($urandom()));
    step(6);
    @(negedge clk);
    chk("full_pre_rptr", rptr, 3);
    chk("full_pre", full, 0);
    step(1);
    for (int i = 0; i < 63; i++) push(16'($urandom()));
    step(2);
    @(negedge clk);
    chk("full_set", full, 1);
    chk("full_rptr", rptr, 3);
    step(1);
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("full_clear", full, 0);
    chk("full_drain_rptr", rptr, 4);
    step(1);
    for (int i = 0; i < 101; i++) begin
      push(16'($urandom()));
      step(1);
    end
    step(90);
    @(negedge clk);
    chk("wrap_rptr", rptr, 40);
    chk("wrap_words", words, 84);
    chk("wrap_toks", toks, 42);
    chk("wrap_valid", valid, 0);
    chk("wrap_left", exp_q.size(), 0);

    // mid-word reset
    step(1);
    do_reset();
    push(16'hDEAD);
    step(1);
    @(negedge clk);
    chk("mid_rptr", rptr, 1);
    chk("mid_valid", valid, 0);
    step(1);
    do_reset();
    @(negedge clk);
    chk("mrst_rptr", rptr, 0);
    chk("mrst_valid", valid, 0);
    chk("mrst_tok", tok, 0);
    chk("mrst_full", full, 0);
    step(1);
    b[0] = 16'($urandom());
    b[1] = 16'($urandom());
    push(b[0]);
    push(b[1]);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mrst_fresh_valid", valid, 1);
    chk("mrst_fresh_word", dout, {b[0], b[1]});
    chk("mrst_fresh_rptr", rptr, 2);

    // RATIO=1, 32-bit entries
    step(1);
    ready1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e[i] = $urandom();
      push1(e[i]);
    end
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("r1_valid", valid1, 1);
      chk("r1_data", dout1, e[i]);
      chk("r1_tok", tok1, (i == 3 || i == 7) ? 1 : 0);
    end
    @(negedge clk);
    chk("r1_idle", valid1, 0);
    chk("r1_rptr", rptr1, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
